// File: rtl/alu_pkg.sv
// Shared ALU opcode and issue-FSM definitions, used by the issue unit and the external ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        AND = 4'd3,
        OR  = 4'd4,
        XOR = 4'd5,
        NOT = 4'd6,
        SLL = 4'd7,
        SRL = 4'd8
    } alu_op_t;

    // Every opcode above this value is rejected without touching the ALU.
    localparam alu_op_t LAST_OP = SRL;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

endpackage

// File: rtl/alu_issue_unit.sv
// Accepts one command at a time, holds it on an external ALU for ALULatency cycles,
// then presents the captured result until the consumer takes it.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int dataWidth   = 32,
    parameter int selectWidth = 4,
    parameter int ALULatency  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic [selectWidth-1:0] cmdOp,
    input  logic [dataWidth-1:0]   cmdA,
    input  logic [dataWidth-1:0]   cmdB,
    output logic [dataWidth-1:0]   inputA,
    output logic [dataWidth-1:0]   inputB,
    output logic [selectWidth-1:0] ALUSelect,
    input  logic [dataWidth-1:0]   dataOut,
    input  logic [dataWidth-1:0]   dataOutHigh,
    output logic                   rspValid,
    input  logic                   rspReady,
    output logic [dataWidth-1:0]   rspData,
    output logic [dataWidth-1:0]   rspDataHigh,
    output logic                   rspError,
    output logic [15:0]            doneCount
);

    state_t                 state;
    state_t                 state_next;
    logic [selectWidth-1:0] op_reg;
    logic [dataWidth-1:0]   a_reg;
    logic [dataWidth-1:0]   b_reg;
    logic [3:0]             count;
    logic                   accept;
    logic                   op_legal;
    logic                   last_issue;
    logic                   rsp_done;

    assign cmdReady   = (state == IDLE);
    assign rspValid   = (state == RESP);
    assign accept     = cmdValid && cmdReady;
    assign op_legal   = (int'(cmdOp) <= int'(LAST_OP));
    assign last_issue = (state == ISSUE) && (count == 4'd1);
    assign rsp_done   = rspValid && rspReady;

    // The ALU only ever sees the registered command, and only while it is being issued.
    assign inputA    = (state == ISSUE) ? a_reg  : '0;
    assign inputB    = (state == ISSUE) ? b_reg  : '0;
    assign ALUSelect = (state == ISSUE) ? op_reg : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = op_legal ? ISSUE : RESP;
            ISSUE:   if (count == 4'd1) state_next = RESP;
            RESP:    if (rspReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            count       <= '0;
            rspData     <= '0;
            rspDataHigh <= '0;
            rspError    <= 1'b0;
            doneCount   <= '0;
        end else begin
            if (accept) begin
                op_reg <= cmdOp;
                a_reg  <= cmdA;
                b_reg  <= cmdB;
                count  <= op_legal ? 4'(ALULatency) : 4'd0;
                // An illegal opcode skips the ALU and responds with an all-zero error result.
                if (!op_legal) begin
                    rspData     <= '0;
                    rspDataHigh <= '0;
                    rspError    <= 1'b1;
                end
            end
            if (state == ISSUE) begin
                count <= count - 4'd1;
            end
            if (last_issue) begin
                rspData     <= dataOut;
                rspDataHigh <= dataOutHigh;
                rspError    <= 1'b0;
            end
            if (rsp_done) begin
                doneCount <= doneCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Drives two issue units (ALULatency 1 and 3) against a latency-aware ALU model and
// compares every cycle of each transaction with the expected protocol behaviour.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid [2];
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_ready;
    logic [31:0] alu_lo [2];
    logic [31:0] alu_hi [2];

    logic        ready_f, valid_f, err_f, ready_s, valid_s, err_s;
    logic [31:0] in_a_f, in_b_f, data_f, high_f, in_a_s, in_b_s, data_s, high_s;
    logic [3:0]  sel_f, sel_s;
    logic [15:0] done_f, done_s;

    logic        obs_ready [2];
    logic        obs_valid [2];
    logic        obs_err   [2];
    logic [31:0] obs_a     [2];
    logic [31:0] obs_b     [2];
    logic [31:0] obs_data  [2];
    logic [31:0] obs_high  [2];
    logic [3:0]  obs_sel   [2];
    logic [15:0] obs_done  [2];

    logic [67:0] alu_in  [2];
    logic [67:0] prev_in [2] = '{default: '0};
    int          stable  [2] = '{default: 0};
    int          age     [2];
    logic [63:0] alu_res [2];

    int          assertions = 0;
    int          failures   = 0;
    logic [15:0] exp_done [2];

    always #5 clk = ~clk;

    alu_issue_unit #(.dataWidth(32), .selectWidth(4), .ALULatency(1)) dut_fast (
        .clk(clk), .reset(reset), .cmdValid(cmd_valid[0]), .cmdReady(ready_f),
        .cmdOp(cmd_op), .cmdA(cmd_a), .cmdB(cmd_b),
        .inputA(in_a_f), .inputB(in_b_f), .ALUSelect(sel_f),
        .dataOut(alu_lo[0]), .dataOutHigh(alu_hi[0]),
        .rspValid(valid_f), .rspReady(rsp_ready), .rspData(data_f),
        .rspDataHigh(high_f), .rspError(err_f), .doneCount(done_f)
    );

    alu_issue_unit #(.dataWidth(32), .selectWidth(4), .ALULatency(3)) dut_slow (
        .clk(clk), .reset(reset), .cmdValid(cmd_valid[1]), .cmdReady(ready_s),
        .cmdOp(cmd_op), .cmdA(cmd_a), .cmdB(cmd_b),
        .inputA(in_a_s), .inputB(in_b_s), .ALUSelect(sel_s),
        .dataOut(alu_lo[1]), .dataOutHigh(alu_hi[1]),
        .rspValid(valid_s), .rspReady(rsp_ready), .rspData(data_s),
        .rspDataHigh(high_s), .rspError(err_s), .doneCount(done_s)
    );

    always_comb begin
        obs_ready[0] = ready_f;  obs_ready[1] = ready_s;
        obs_valid[0] = valid_f;  obs_valid[1] = valid_s;
        obs_err[0]   = err_f;    obs_err[1]   = err_s;
        obs_a[0]     = in_a_f;   obs_a[1]     = in_a_s;
        obs_b[0]     = in_b_f;   obs_b[1]     = in_b_s;
        obs_data[0]  = data_f;   obs_data[1]  = data_s;
        obs_high[0]  = high_f;   obs_high[1]  = high_s;
        obs_sel[0]   = sel_f;    obs_sel[1]   = sel_s;
        obs_done[0]  = done_f;   obs_done[1]  = done_s;
    end

    function automatic int latency_of(input int u);
        return (u == 1) ? 3 : 1;
    endfunction

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'h0, a};
        wb = {32'h0, b};
        case (op)
            4'd0:    return wa + wb;
            4'd1:    return wa - wb;
            4'd2:    return wa * wb;
            4'd3:    return {32'h0, a & b};
            4'd4:    return {32'h0, a | b};
            4'd5:    return {32'h0, a ^ b};
            4'd6:    return {32'h0, ~a};
            4'd7:    return {32'h0, a << b[4:0]};
            4'd8:    return {32'h0, a >> b[4:0]};
            default: return 64'h0;
        endcase
    endfunction

    // ALU model: the result is only valid once its inputs have been held for the full latency.
    always_comb begin
        for (int u = 0; u < 2; u++) begin
            alu_in[u]  = {obs_sel[u], obs_a[u], obs_b[u]};
            age[u]     = (alu_in[u] == prev_in[u]) ? stable[u] + 1 : 0;
            alu_res[u] = alu_ref(obs_sel[u], obs_a[u], obs_b[u]);
            if (age[u] >= latency_of(u) - 1) begin
                alu_lo[u] = alu_res[u][31:0];
                alu_hi[u] = alu_res[u][63:32];
            end else begin
                alu_lo[u] = 32'hDEADBEEF;
                alu_hi[u] = 32'hBAADF00D;
            end
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            stable[u]  <= age[u];
            prev_in[u] <= alu_in[u];
        end
    end

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int u, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int stall);
        int          resp_cycle;
        bit          legal;
        logic [64:0] exp_rsp;
        logic [67:0] exp_alu;
        legal      = (op <= 4'd8);
        resp_cycle = legal ? latency_of(u) + 1 : 1;
        exp_rsp    = legal ? {1'b0, alu_ref(op, a, b)} : {1'b1, 64'h0};

        @(negedge clk);
        check_output("cmdReady idle", obs_ready[u], 1'b1);
        cmd_op       = op;
        cmd_a        = a;
        cmd_b        = b;
        cmd_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[u] = 1'b0;
        cmd_op       = 4'($urandom);
        cmd_a        = $urandom;
        cmd_b        = $urandom;

        for (int c = 1; c <= resp_cycle; c++) begin
            @(negedge clk);
            exp_alu = (legal && c <= latency_of(u)) ? {op, a, b} : 68'h0;
            check_output("alu drive", {obs_sel[u], obs_a[u], obs_b[u]}, exp_alu);
            check_output("cmdReady busy", obs_ready[u], 1'b0);
            check_output("rspValid timing", obs_valid[u], (c == resp_cycle));
        end
        check_output("response", {obs_err[u], obs_high[u], obs_data[u]}, exp_rsp);
        check_output("doneCount hold", obs_done[u], exp_done[u]);

        // Commands offered while a response is pending must be ignored.
        for (int s = 0; s < stall; s++) begin
            cmd_valid[u] = 1'b1;
            cmd_op       = 4'($urandom_range(0, 8));
            @(negedge clk);
            check_output("stall valid", obs_valid[u], 1'b1);
            check_output("stall response", {obs_err[u], obs_high[u], obs_data[u]}, exp_rsp);
            check_output("stall cmdReady", obs_ready[u], 1'b0);
            check_output("stall doneCount", obs_done[u], exp_done[u]);
        end
        cmd_valid[u] = 1'b0;
        rsp_ready    = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready   = 1'b0;
        exp_done[u] = exp_done[u] + 16'd1;
        @(negedge clk);
        check_output("release valid", obs_valid[u], 1'b0);
        check_output("release cmdReady", obs_ready[u], 1'b1);
        check_output("release doneCount", obs_done[u], exp_done[u]);
    endtask

    initial begin
        logic [3:0] op;
        int         u;
        reset        = 1'b1;
        cmd_valid[0] = 1'b0;
        cmd_valid[1] = 1'b0;
        cmd_op       = '0;
        cmd_a        = '0;
        cmd_b        = '0;
        rsp_ready    = 1'b0;
        exp_done[0]  = '0;
        exp_done[1]  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_output("reset cmdReady", obs_ready[k], 1'b1);
            check_output("reset rspValid", obs_valid[k], 1'b0);
            check_output("reset rspError", obs_err[k], 1'b0);
            check_output("reset rspData", {obs_high[k], obs_data[k]}, 64'h0);
            check_output("reset alu", {obs_sel[k], obs_a[k], obs_b[k]}, 68'h0);
            check_output("reset doneCount", obs_done[k], 16'h0);
        end

        $display("[TB] directed commands");
        apply_stimulus(0, 4'd0, 32'h8, 32'h8, 0);
        check_output("add result", obs_data[0], 32'h10);
        apply_stimulus(1, 4'd2, 32'hFFFFFFFF, 32'h2, 0);
        check_output("mul high", {obs_high[1], obs_data[1]}, 64'h1_FFFFFFFE);
        apply_stimulus(0, 4'd1, 32'h3, 32'h7, 5);
        check_output("sub result", obs_data[0], 32'hFFFFFFFC);
        apply_stimulus(0, 4'hC, 32'h55, 32'hAA, 2);

        $display("[TB] reset during issue");
        @(negedge clk);
        cmd_op       = 4'd2;
        cmd_a        = 32'h1234;
        cmd_b        = 32'h10;
        cmd_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        check_output("issue before reset", obs_sel[1], 4'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        exp_done[0] = '0;
        exp_done[1] = '0;
        @(negedge clk);
        check_output("post-reset valid", obs_valid[1], 1'b0);
        check_output("post-reset cmdReady", obs_ready[1], 1'b1);
        check_output("post-reset alu", {obs_sel[1], obs_a[1], obs_b[1]}, 68'h0);
        check_output("post-reset doneCount", obs_done[1], 16'h0);
        repeat (4) begin
            @(negedge clk);
            check_output("discarded command", obs_valid[1], 1'b0);
        end

        $display("[TB] doneCount wrap");
        @(negedge clk);
        force dut_fast.doneCount = 16'hFFFF;
        #1;
        release dut_fast.doneCount;
        exp_done[0] = 16'hFFFF;
        @(negedge clk);
        check_output("preloaded doneCount", obs_done[0], 16'hFFFF);
        apply_stimulus(0, 4'd4, 32'hF0, 32'h0F, 1);
        check_output("wrapped doneCount", obs_done[0], 16'h0000);

        $display("[TB] random commands");
        for (int i = 0; i < 60; i++) begin
            u  = int'($urandom_range(0, 1));
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            apply_stimulus(u, op, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
